// File: rtl/config_pkg.sv
// Shared configuration for the row-wise datapath: vector geometry and element types.
package config_pkg;

   localparam int unsigned VECTOR_LEN = 4;
   localparam int unsigned ELEM_WIDTH = 8;

   typedef logic [ELEM_WIDTH-1:0]  element_t;
   typedef element_t [VECTOR_LEN-1:0] vector_t;

endpackage

// File: rtl/vector_serializer.sv
// Accepts a whole vector from the row-wise stage and streams its elements one per
// handshake, with zero-bubble hand-over from one vector to the next.
module vector_serializer
   import config_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  vector_t             vector_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output element_t            elem_o,
   output logic [((VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1)-1:0] index_o,
   output logic                last_o,
   output logic                out_valid_o,
   input  logic                out_ready_i
);

   localparam int unsigned IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;

   localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(VECTOR_LEN - 1);
   localparam logic [IDX_W-1:0] FIRST_IDX = LSB_FIRST ? {IDX_W{1'b0}} : TOP_IDX;
   localparam logic [IDX_W-1:0] LAST_IDX  = LSB_FIRST ? TOP_IDX : {IDX_W{1'b0}};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state_r;
   vector_t          vec_r;
   logic [IDX_W-1:0] cnt_r;

   logic             last_s;
   logic             in_xfer_s;
   logic             out_xfer_s;
   logic [IDX_W-1:0] cnt_step_s;

   assign last_s      = (cnt_r == LAST_IDX);
   assign out_valid_o = (state_r == SEND);
   assign out_xfer_s  = out_valid_o && out_ready_i;

   // Ready while idle, or when the final element leaves this very cycle.
   assign in_ready_o  = (state_r == IDLE) || (out_xfer_s && last_s);
   assign in_xfer_s   = in_valid_i && in_ready_o;

   assign cnt_step_s  = LSB_FIRST ? (cnt_r + IDX_W'(1)) : (cnt_r - IDX_W'(1));

   // Outputs come straight from the captured vector and the registered counter.
   assign elem_o      = vec_r[cnt_r];
   assign index_o     = cnt_r;
   assign last_o      = last_s;

   // Handshake FSM, vector capture and element counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         cnt_r   <= FIRST_IDX;
         vec_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_xfer_s) begin
                  vec_r   <= vector_i;
                  cnt_r   <= FIRST_IDX;
                  state_r <= SEND;
               end else begin
                  state_r <= IDLE;
               end
            end
            SEND: begin
               if (in_xfer_s) begin
                  vec_r   <= vector_i;
                  cnt_r   <= FIRST_IDX;
                  state_r <= SEND;
               end else if (out_xfer_s && last_s) begin
                  cnt_r   <= FIRST_IDX;
                  state_r <= IDLE;
               end else if (out_xfer_s) begin
                  cnt_r   <= cnt_step_s;
                  state_r <= SEND;
               end else begin
                  state_r <= SEND;
               end
            end
            default: begin
               cnt_r   <= FIRST_IDX;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
